// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// shifter FSM states, register word offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_OVF      = 3;
  localparam int ST_PARITY   = 4;
  localparam int ST_COUNT_LO = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers; the head entry is
// visible on dout so a pop and its data land on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign dout  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus decode, STATUS register and shifter FSM.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  wr_strobe,
  input  logic        rd_strobe,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam int             NW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

  logic            sel;
  logic [1:0]      offset;
  logic            wr_txdata;
  logic            ovf_clr;
  logic            full;
  logic            empty;
  logic [NW-1:0]   count;
  logic [7:0]      fifo_dout;
  logic            pop;
  logic            ovf_reg;
  logic [3:0]      count_sat;
  logic [31:0]     status;
  logic [31:0]     rd_word;

  tx_state_t       state_reg, state_next;
  logic [CW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shifter_reg, shifter_next;
  logic            tx_next;

  logic unused_bits;
  assign unused_bits = ^{data_in[31:8], wr_strobe[3:1], addr[1:0]};

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:2];
  assign wr_txdata = sel && (offset == TXDATA) && wr_strobe[0];
  assign ovf_clr   = sel && (offset == STATUS) && wr_strobe[0] && data_in[3];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (data_in[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    count_sat = 4'hF;
    if (32'(count) < 32'd15) count_sat = 4'(count);
  end

  always_comb begin
    status                      = '0;
    status[ST_BUSY]             = (state_reg != IDLE);
    status[ST_FULL]             = full;
    status[ST_EMPTY]            = empty;
    status[ST_OVF]              = ovf_reg;
    status[ST_COUNT_LO +: 4]    = count_sat;
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY]           = 1'b1;
`endif
  end

  assign rd_word = (offset == STATUS) ? status : 32'h0;

  // Read data is captured from pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      if (rd_strobe && sel) data_out <= rd_word;
      if (wr_txdata && full) ovf_reg <= 1'b1;
      else if (ovf_clr)      ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shifter_reg <= '0;
      tx          <= 1'b1;
      irq         <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shifter_reg <= shifter_next;
      tx          <= tx_next;
      irq         <= empty && (state_reg == IDLE);
    end
  end

  // The shifter rotates rather than shifts so the full byte is intact for parity.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shifter_next = shifter_reg;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          shifter_next = fifo_dout;
          baud_next    = BAUD_LOAD;
          state_next   = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_reg == '0) begin
          baud_next    = BAUD_LOAD;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg - CW'(1);
        end
      end
      DATA: begin
        tx_next = shifter_reg[0];
        if (baud_reg == '0) begin
          baud_next    = BAUD_LOAD;
          shifter_next = {shifter_reg[0], shifter_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud_reg - CW'(1);
        end
      end
      PARITY: begin
        tx_next = ^shifter_reg;
        if (baud_reg == '0) begin
          baud_next  = BAUD_LOAD;
          state_next = STOP;
        end else begin
          baud_next = baud_reg - CW'(1);
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_reg == '0) state_next = IDLE;
        else                baud_next  = baud_reg - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed-plus-random bench for uart_tx_mmio; a line-level receiver model
// decodes tx into bytes that are compared against what was written.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int          C     = 4;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          NB    = 11;
  localparam logic [31:0] PBIT  = 32'h10;
`else
  localparam int          NB    = 10;
  localparam logic [31:0] PBIT  = 32'h0;
`endif
  localparam logic [31:0] IDLE_ST = 32'h4 | PBIT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [3:0]  wr_strobe;
  logic        rd_strobe;
  logic [31:0] data_out;
  logic        tx;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  logic       exp_q[$];

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .data_out  (data_out),
    .tx        (tx),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line level per cycle: start, data LSB first, optional even parity, stop.
  function automatic void add_frame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (NB == 11) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < C; c++) exp_q.push_back(bits[i]);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; data_in = d; wr_strobe = s;
    @(posedge clk);
    #1;
    wr_strobe = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    rd_strobe = 1'b0;
    d = data_out;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (irq !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
    repeat (2 * C) @(negedge clk);
  endtask

  // Receiver model: samples mid-bit, drops frames that overlap a reset.
  logic [7:0] mon_byte;
  logic       mon_bad;
  logic       mon_ab;

  task automatic mon_step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst === 1'b1) mon_ab = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        mon_ab = 1'b0; mon_bad = 1'b0; mon_byte = 8'h00;
        mon_step(C / 2);
        if (tx !== 1'b0) mon_bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          mon_step(C);
          mon_byte[i] = tx;
        end
        if (NB == 11) begin
          mon_step(C);
          if (tx !== ^mon_byte) mon_bad = 1'b1;
        end
        mon_step(C);
        if (tx !== 1'b1) mon_bad = 1'b1;
        if (!mon_ab) begin
          if (mon_bad) frame_err++;
          else         rx_q.push_back(mon_byte);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d, exp_st, obs, expw;
    logic [7:0]  bytes[8];
    logic [7:0]  b;
    int          k, acc, errs, berrs;
    int          ks[4];
    logic [31:0] offs[3];

    rst = 1'b1; addr = '0; data_in = '0; wr_strobe = '0; rd_strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq), 32'd1);
    chk("reset_dout", data_out, 32'd0);
    bus_read(BASE + 32'h4, rd);
    chk("reset_status", rd, IDLE_ST);

    // Single 0xA5 frame checked cycle by cycle.
    d = $urandom(); d[7:0] = 8'hA5;
    bus_write(BASE, d, 4'b0001);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < 50);
    chk("a5_first_fall", k, 32'd3);
    exp_q.delete();
    add_frame(8'hA5);
    for (int i = 0; i < NB; i++) begin
      obs = '0; expw = '0;
      for (int c = 0; c < C; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        obs[c]  = tx;
        expw[c] = exp_q[i * C + c];
      end
      chk($sformatf("a5_bit%0d", i), obs, expw);
    end
    repeat (2) @(negedge clk);
    chk("a5_irq_after_stop", 32'(irq), 32'd1);
    chk("a5_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("a5_rx_byte", 32'(rx_q.pop_front()), 32'hA5);

    // Random single bytes.
    for (int t = 0; t < 3; t++) begin
      b = 8'($urandom_range(0, 255));
      d = $urandom(); d[7:0] = b;
      bus_write(BASE, d, 4'b0001);
      wait_idle("single_idle");
      chk("single_rx_count", rx_q.size(), 32'd1);
      if (rx_q.size() > 0) chk("single_rx_byte", 32'(rx_q.pop_front()), 32'(b));
    end

    // Bursts: the shifter takes one byte, DEPTH more queue, the rest drop.
    ks[0] = 6;
    for (int t = 1; t < 4; t++) ks[t] = int'($urandom_range(1, 7));
    for (int t = 0; t < 4; t++) begin
      k = ks[t];
      for (int j = 0; j < k; j++) begin
        bytes[j] = 8'($urandom());
        d = $urandom(); d[7:0] = bytes[j];
        bus_write(BASE, d, 4'b0001);
      end
      @(negedge clk);
      bus_read(BASE + 32'h4, rd);
      acc = (k < DEPTH + 1) ? k : DEPTH + 1;
      exp_st = 32'h1 | PBIT | (32'(acc - 1) << 8);
      if (acc - 1 == DEPTH) exp_st = exp_st | 32'h2;
      if (acc - 1 == 0)     exp_st = exp_st | 32'h4;
      if (k > acc)          exp_st = exp_st | 32'h8;
      chk($sformatf("burst%0d_status", k), rd, exp_st);
      if (k > acc) begin
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);
        bus_read(BASE + 32'h4, rd);
        chk("ovf_cleared", 32'(rd[3]), 32'd0);
      end
      wait_idle("burst_idle");
      chk("burst_rx_count", rx_q.size(), 32'(acc));
      for (int j = 0; j < acc; j++)
        if (rx_q.size() > 0) chk("burst_rx_byte", 32'(rx_q.pop_front()), 32'(bytes[j]));
    end

    // Back-to-back 0x01, 0x02 with STATUS polled every cycle.
    bus_write(BASE, 32'h01, 4'b0001);
    bus_write(BASE, 32'h02, 4'b0001);
    @(negedge clk);
    addr = BASE + 32'h4; rd_strobe = 1'b1;
    exp_q.delete();
    add_frame(8'h01);
    exp_q.push_back(1'b1);
    add_frame(8'h02);
    errs = 0; berrs = 0;
    for (int s = 0; s < 2 * NB * C + 1; s++) begin
      @(negedge clk);
      if (tx !== exp_q[s]) errs++;
      if (data_out[0] !== (s != NB * C)) berrs++;
    end
    rd_strobe = 1'b0;
    chk("b2b_tx_errors", errs, 32'd0);
    chk("b2b_busy_errors", berrs, 32'd0);
    wait_idle("b2b_idle");
    chk("b2b_rx_count", rx_q.size(), 32'd2);
    if (rx_q.size() > 0) chk("b2b_rx_byte0", 32'(rx_q.pop_front()), 32'h01);
    if (rx_q.size() > 0) chk("b2b_rx_byte1", 32'(rx_q.pop_front()), 32'h02);

    // Reset during data bit 3, with a second byte still queued.
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'hFF : 8'h00;
      bus_write(BASE, 32'(b), 4'b0001);
      bus_write(BASE, 32'h3C, 4'b0001);
      repeat (19) @(negedge clk);
      chk("rst_pre_tx", 32'(tx), 32'(b[3]));
      #2 rst = 1'b1;
      #1;
      chk("rst_async_tx", 32'(tx), 32'd1);
      chk("rst_async_irq", 32'(irq), 32'd1);
      chk("rst_async_dout", data_out, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      errs = 0;
      for (int s = 0; s < 3 * NB * C; s++) begin
        @(negedge clk);
        if (tx !== 1'b1) errs++;
      end
      chk("rst_no_frame_tx", errs, 32'd0);
      chk("rst_rx_count", rx_q.size(), 32'd0);
      bus_read(BASE + 32'h4, rd);
      chk("rst_status", rd, IDLE_ST);
    end

    // Outside the window and unused offsets.
    bus_write(BASE + 32'h10, 32'h55, 4'b0001);
    bus_write(BASE + 32'h8, 32'h66, 4'b0001);
    bus_write(BASE + 32'hC, 32'h77, 4'b0001);
    bus_read(BASE + 32'h14, rd);
    chk("oow_read_holds", rd, IDLE_ST);
    repeat (2 * NB * C) @(negedge clk);
    chk("oow_rx_count", rx_q.size(), 32'd0);
    chk("oow_irq", 32'(irq), 32'd1);
    offs[0] = BASE; offs[1] = BASE + 32'h8; offs[2] = BASE + 32'hC;
    for (int j = 0; j < 3; j++) begin
      bus_read(BASE + 32'h4, rd);
      chk("oow_status", rd, IDLE_ST);
      bus_read(offs[j], rd);
      chk($sformatf("read_zero_%0h", offs[j][3:0]), rd, 32'd0);
    end

    chk("frame_errors", frame_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
